// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, h/v counters, zero-skew sync/bright
// decode and a one-cycle frame strobe, all in the single clk domain.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       frame_tick
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned CNT_W = 10;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_n;
    logic [CNT_W-1:0] h_n;
    logic [CNT_W-1:0] v_n;
    logic             wrap_c;

    // Next-state values; decode uses these so outputs line up with the counters.
    always_comb begin
        div_n  = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
        h_n    = hCount;
        v_n    = vCount;
        wrap_c = 1'b0;
        if (pix_tick) begin
            if (hCount == CNT_W'(H_TOTAL - 1)) begin
                h_n = '0;
                if (vCount == CNT_W'(V_TOTAL - 1)) begin
                    v_n    = '0;
                    wrap_c = 1'b1;
                end else begin
                    v_n = vCount + CNT_W'(1);
                end
            end else begin
                h_n = hCount + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            pix_tick   <= 1'b0;
            hCount     <= '0;
            vCount     <= '0;
            bright     <= 1'b0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            div        <= div_n;
            pix_tick   <= (div_n == DIV_W'(CLK_DIV - 1));
            hCount     <= h_n;
            vCount     <= v_n;
            hSync      <= !(h_n < CNT_W'(H_SYNC));
            vSync      <= !(v_n < CNT_W'(V_SYNC));
            bright     <= (h_n >= CNT_W'(H_ACT_START)) && (h_n < CNT_W'(H_ACT_END)) &&
                          (v_n >= CNT_W'(V_ACT_START)) && (v_n < CNT_W'(V_ACT_END));
            frame_tick <= wrap_c;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a scaled-down raster (20x12 pixels, CLK_DIV 4)
// so that full frames, frame wraps and a mid-frame reset fit in a short run.
module tb_vga_timing_gen;

    localparam int CD    = 4;
    localparam int HT    = 20;
    localparam int HS    = 3;
    localparam int HAS   = 5;
    localparam int HAE   = 17;
    localparam int VT    = 12;
    localparam int VS    = 2;
    localparam int VAS   = 4;
    localparam int VAE   = 10;
    localparam int FRAME = HT * VT * CD;

    typedef struct {
        int cyc;
        int h;
        int v;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_tick;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       hSync;
    logic       vSync;
    logic       frame_tick;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE)
    ) dut (
        .clk(clk), .rst(rst), .pix_tick(pix_tick), .hCount(hCount), .vCount(vCount),
        .bright(bright), .hSync(hSync), .vSync(vSync), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   base = 0;
    bit   armed = 1'b0;
    bit   phase1 = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   hs_low = 0;
    int   vs_low = 0;
    int   br_hi = 0;
    pix_t pix_q[$];
    int   ft_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    function automatic int exp_bright(input int h, input int v);
        return int'(h >= HAS && h < HAE && v >= VAS && v < VAE);
    endfunction

    // Monitor: per-cycle decode/counter checks plus scoreboard pops on pix_tick/frame_tick.
    always @(negedge clk) begin : mon
        int   rel;
        int   k;
        pix_t p;
        int   fc;
        if (armed) begin
            rel = cyc - base;
            k   = rel / CD;
            check_eq("hcount", int'(hCount), k % HT);
            check_eq("vcount", int'(vCount), (k / HT) % VT);
            check_eq("pix_tick", int'(pix_tick), int'(rel % CD == CD - 1));
            check_eq("bright", int'(bright), exp_bright(int'(hCount), int'(vCount)));
            check_eq("hsync", int'(hSync), int'(int'(hCount) >= HS));
            check_eq("vsync", int'(vSync), int'(int'(vCount) >= VS));
            if (pix_tick) begin
                if (pix_q.size() == 0) begin
                    check_eq("pix_unexpected", pix_q.size(), 1);
                end else begin
                    p = pix_q.pop_front();
                    check_eq("pix_cycle", rel, p.cyc - base);
                    check_eq("pix_h", int'(hCount), p.h);
                    check_eq("pix_v", int'(vCount), p.v);
                end
            end
            if (frame_tick) begin
                if (ft_q.size() == 0) begin
                    check_eq("frame_unexpected", ft_q.size(), 1);
                end else begin
                    fc = ft_q.pop_front();
                    check_eq("frame_cycle", rel, fc - base);
                    check_eq("frame_h", int'(hCount), 0);
                    check_eq("frame_v", int'(vCount), 0);
                end
            end
            if (phase1 && rel < 2 * FRAME) begin
                if (!hSync) hs_low++;
                if (!vSync) vs_low++;
                if (bright) br_hi++;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_hcount"}, int'(hCount), 0);
        check_eq({tag, "_vcount"}, int'(vCount), 0);
        check_eq({tag, "_pix_tick"}, int'(pix_tick), 0);
        check_eq({tag, "_bright"}, int'(bright), 0);
        check_eq({tag, "_hsync"}, int'(hSync), 0);
        check_eq({tag, "_vsync"}, int'(vSync), 0);
        check_eq({tag, "_frame_tick"}, int'(frame_tick), 0);
    endtask

    task automatic push_pixels(input int npix);
        pix_t p;
        for (int k = 0; k < npix; k++) begin
            p.cyc = base + CD * k + CD - 1;
            p.h   = k % HT;
            p.v   = (k / HT) % VT;
            pix_q.push_back(p);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((pix_q.size() + ft_q.size()) != 0 && n < 3 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, pix_q.size() + ft_q.size(), 0);
    endtask

    initial begin : stim
        int  n;
        bit  found;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        check_reset_state("reset");

        push_pixels(2 * HT * VT + 1);
        ft_q.push_back(base + FRAME);
        ft_q.push_back(base + 2 * FRAME);
        phase1 = 1'b1;
        armed  = 1'b1;
        drain("phase1_drain");
        armed  = 1'b0;
        phase1 = 1'b0;

        // Two frames: 24 lines x 3 px x 4 clks hsync low, 2 x 2 lines vsync low,
        // 2 x 6 lines x 12 px x 4 clks bright.
        check_eq("hsync_low_clks", hs_low, 288);
        check_eq("vsync_low_clks", vs_low, 320);
        check_eq("bright_clks", br_hi, 576);

        found = 1'b0;
        n = 0;
        while (!found && n < 2 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
            if (hCount == 10'd10 && vCount == 10'd5) found = 1'b1;
        end
        check_eq("midframe_found", int'(found), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        check_reset_state("midreset");

        push_pixels(HT * VT + 1);
        ft_q.push_back(base + FRAME);
        armed = 1'b1;
        drain("phase2_drain");
        armed = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
